typing_round_ctrl: RTL and testbench



---
 rtl/typing_round_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_typing_round_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_round_ctrl.sv
// -----------------------------------------------------------------------------
// typing_round_ctrl
//
// Round controller for the typing tutor. It arms and runs the countdown timer,
// scores keystrokes against a combinational target-text ROM, and ends the round
// when the whole text has been typed or when the timer runs out.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   start          begin a round (only looked at in IDLE and DONE)
//   time_left      countdown value from the timer
//   key_valid      keystroke present on key_code
//   key_code       ASCII code of the keystroke
//   target_code    ROM data at target_addr (same-cycle combinational ROM)
//   tmr_enable     timer count enable (high while in RUN)
//   tmr_clear      one-cycle pulse that reloads the timer (high in ARM)
//   key_ready      keys are accepted this cycle (decoded from state)
//   target_addr    index of the next expected character
//   correct_count  accepted matching keys, saturating
//   error_count    accepted mismatching keys, saturating
//   round_done     high while in DONE
//   completed      round ended by finishing the text
//   timed_out      round ended by the timer expiring
//   state          IDLE=0, ARM=1, RUN=2, DONE=3
// -----------------------------------------------------------------------------
module typing_round_ctrl #(
  parameter int TEXT_LEN = 16,
  parameter int ADDR_W   = 4,
  parameter int TIME_W   = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [TIME_W-1:0] time_left,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  input  logic [7:0]        target_code,
  output logic              tmr_enable,
  output logic              tmr_clear,
  output logic              key_ready,
  output logic [ADDR_W-1:0] target_addr,
  output logic [CNT_W-1:0]  correct_count,
  output logic [CNT_W-1:0]  error_count,
  output logic              round_done,
  output logic              completed,
  output logic              timed_out,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEXT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] target_addr_q, target_addr_d;
  logic [CNT_W-1:0]  correct_count_q, correct_count_d;
  logic [CNT_W-1:0]  error_count_q, error_count_d;
  logic              completed_q, completed_d;
  logic              timed_out_q, timed_out_d;
  logic              seen_nonzero_q, seen_nonzero_d;
  logic              tmr_enable_q, tmr_enable_d;
  logic              tmr_clear_q, tmr_clear_d;
  logic              round_done_q, round_done_d;

  logic key_accept;
  logic key_match;
  logic text_finished;

  // NUL keystrokes are dropped before scoring so they never touch a counter.
  assign key_accept = key_valid && (state_q == RUN) && (key_code != 8'h00);
  assign key_match  = (key_code == target_code);

  // Next-state and scoring logic. Within a RUN cycle the key is scored first,
  // so a key that completes the text takes priority over a simultaneous expiry.
  // The expiry check uses the registered seen_nonzero so that a stale zero left
  // over from the previous round (before the reload lands) cannot end the round.
  always_comb begin
    state_d         = state_q;
    target_addr_d   = target_addr_q;
    correct_count_d = correct_count_q;
    error_count_d   = error_count_q;
    completed_d     = completed_q;
    timed_out_d     = timed_out_q;
    seen_nonzero_d  = seen_nonzero_q;
    text_finished   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
        end
      end

      ARM: begin
        target_addr_d   = '0;
        correct_count_d = '0;
        error_count_d   = '0;
        completed_d     = 1'b0;
        timed_out_d     = 1'b0;
        seen_nonzero_d  = 1'b0;
        state_d         = RUN;
      end

      RUN: begin
        if (key_accept) begin
          if (key_match) begin
            if (correct_count_q != CNT_MAX) begin
              correct_count_d = correct_count_q + CNT_ONE;
            end
            if (target_addr_q == LAST_ADDR) begin
              target_addr_d = '0;
              completed_d   = 1'b1;
              text_finished = 1'b1;
              state_d       = DONE;
            end else begin
              target_addr_d = target_addr_q + ADDR_ONE;
            end
          end else if (error_count_q != CNT_MAX) begin
            error_count_d = error_count_q + CNT_ONE;
          end
        end

        if (!text_finished && (time_left == '0) && seen_nonzero_q) begin
          timed_out_d = 1'b1;
          state_d     = DONE;
        end

        if (time_left != '0) begin
          seen_nonzero_d = 1'b1;
        end
      end

      DONE: begin
        if (start) begin
          state_d = ARM;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered status outputs follow the state being entered, so they line up
  // with the state register on every cycle.
  always_comb begin
    tmr_enable_d = (state_d == RUN);
    tmr_clear_d  = (state_d == ARM);
    round_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      target_addr_q   <= '0;
      correct_count_q <= '0;
      error_count_q   <= '0;
      completed_q     <= 1'b0;
      timed_out_q     <= 1'b0;
      seen_nonzero_q  <= 1'b0;
      tmr_enable_q    <= 1'b0;
      tmr_clear_q     <= 1'b0;
      round_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      target_addr_q   <= target_addr_d;
      correct_count_q <= correct_count_d;
      error_count_q   <= error_count_d;
      completed_q     <= completed_d;
      timed_out_q     <= timed_out_d;
      seen_nonzero_q  <= seen_nonzero_d;
      tmr_enable_q    <= tmr_enable_d;
      tmr_clear_q     <= tmr_clear_d;
      round_done_q    <= round_done_d;
    end
  end

  assign state         = state_q;
  assign key_ready     = (state_q == RUN);
  assign target_addr   = target_addr_q;
  assign correct_count = correct_count_q;
  assign error_count   = error_count_q;
  assign completed     = completed_q;
  assign timed_out     = timed_out_q;
  assign tmr_enable    = tmr_enable_q;
  assign tmr_clear     = tmr_clear_q;
  assign round_done    = round_done_q;

endmodule

// File: tb/tb_typing_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_typing_round_ctrl
//
// Bench for typing_round_ctrl with a four-character target text "abcd".
// A reference model tracks the round as a phase plus scores and is advanced
// once per clock from the same inputs the DUT sees; every output is compared
// just after each rising edge.
// -----------------------------------------------------------------------------
module tb_typing_round_ctrl;

  localparam int TEXT_LEN = 4;
  localparam int ADDR_W   = 2;
  localparam int TIME_W   = 4;
  localparam int CNT_W    = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [TIME_W-1:0] time_left;
  logic              key_valid;
  logic [7:0]        key_code;
  logic [7:0]        target_code;
  logic              tmr_enable;
  logic              tmr_clear;
  logic              key_ready;
  logic [ADDR_W-1:0] target_addr;
  logic [CNT_W-1:0]  correct_count;
  logic [CNT_W-1:0]  error_count;
  logic              round_done;
  logic              completed;
  logic              timed_out;
  logic [1:0]        state;

  logic [7:0] rom [TEXT_LEN];

  int vectors;
  int miscompares;

  // Reference model: phase 0 idle, 1 arming, 2 running, 3 finished.
  int phase;
  int pos;
  int nCorrect;
  int nError;
  int wasCompleted;
  int wasTimedOut;
  int timerSeenLive;

  typing_round_ctrl #(
    .TEXT_LEN(TEXT_LEN),
    .ADDR_W  (ADDR_W),
    .TIME_W  (TIME_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .time_left    (time_left),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .target_code  (target_code),
    .tmr_enable   (tmr_enable),
    .tmr_clear    (tmr_clear),
    .key_ready    (key_ready),
    .target_addr  (target_addr),
    .correct_count(correct_count),
    .error_count  (error_count),
    .round_done   (round_done),
    .completed    (completed),
    .timed_out    (timed_out),
    .state        (state)
  );

  assign target_code = rom[target_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset empties the whole model.
  task automatic modelReset();
    phase         = 0;
    pos           = 0;
    nCorrect      = 0;
    nError        = 0;
    wasCompleted  = 0;
    wasTimedOut   = 0;
    timerSeenLive = 0;
  endtask

  // One clock of round behaviour from the inputs present at the edge.
  task automatic modelStep(input bit st, input bit kv, input logic [7:0] kc,
                           input int tl);
    bit finishedText;
    finishedText = 0;
    if (phase == 0 || phase == 3) begin
      if (st) phase = 1;
    end else if (phase == 1) begin
      pos           = 0;
      nCorrect      = 0;
      nError        = 0;
      wasCompleted  = 0;
      wasTimedOut   = 0;
      timerSeenLive = 0;
      phase         = 2;
    end else begin
      if (kv && kc != 8'h00) begin
        if (kc == rom[pos]) begin
          nCorrect = (nCorrect < 255) ? nCorrect + 1 : 255;
          pos = pos + 1;
          if (pos == TEXT_LEN) begin
            pos          = 0;
            wasCompleted = 1;
            finishedText = 1;
            phase        = 3;
          end
        end else begin
          nError = (nError < 255) ? nError + 1 : 255;
        end
      end
      if (!finishedText && tl == 0 && timerSeenLive != 0) begin
        wasTimedOut = 1;
        phase       = 3;
      end
      if (tl != 0) timerSeenLive = 1;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".state"},         32'(state),         32'(phase));
    checkValue({tag, ".tmr_enable"},    32'(tmr_enable),    32'(phase == 2));
    checkValue({tag, ".tmr_clear"},     32'(tmr_clear),     32'(phase == 1));
    checkValue({tag, ".key_ready"},     32'(key_ready),     32'(phase == 2));
    checkValue({tag, ".round_done"},    32'(round_done),    32'(phase == 3));
    checkValue({tag, ".target_addr"},   32'(target_addr),   32'(pos));
    checkValue({tag, ".correct_count"}, 32'(correct_count), 32'(nCorrect));
    checkValue({tag, ".error_count"},   32'(error_count),   32'(nError));
    checkValue({tag, ".completed"},     32'(completed),     32'(wasCompleted));
    checkValue({tag, ".timed_out"},     32'(timed_out),     32'(wasTimedOut));
  endtask

  // Drive inputs, clock once, advance the model, then check 1 ns after the edge.
  task automatic applyStimulus(input string tag, input bit st, input bit kv,
                               input logic [7:0] kc, input int tl);
    start     = st;
    key_valid = kv;
    key_code  = kc;
    time_left = TIME_W'(tl);
    @(posedge clk);
    modelStep(st, kv, kc, tl);
    #1;
    checkOutput(tag);
  endtask

  task automatic typeKey(input string tag, input logic [7:0] kc, input int tl);
    applyStimulus(tag, 1'b0, 1'b1, kc, tl);
  endtask

  task automatic startRound(input string tag);
    applyStimulus({tag, ".arm"}, 1'b1, 1'b0, 8'h00, 5);
    applyStimulus({tag, ".run"}, 1'b0, 1'b0, 8'h00, 5);
  endtask

  initial begin
    logic [7:0] keyPool [6];
    vectors     = 0;
    miscompares = 0;
    rom[0] = "a";
    rom[1] = "b";
    rom[2] = "c";
    rom[3] = "d";
    keyPool[0] = 8'h00;
    keyPool[1] = "a";
    keyPool[2] = "b";
    keyPool[3] = "c";
    keyPool[4] = "d";
    keyPool[5] = "x";

    start     = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    time_left = '0;
    reset     = 1'b0;
    modelReset();
    #12;
    checkOutput("reset_state");
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_hold");

    // Start pulse: one ARM cycle with the clear pulse, then RUN.
    startRound("start");

    // Full text with one typo.
    typeKey("text.a", "a", 5);
    typeKey("text.x", "x", 5);
    typeKey("text.b", "b", 5);
    typeKey("text.c", "c", 5);
    typeKey("text.d", "d", 5);
    checkValue("text.completed_const", 32'(completed), 32'd1);
    applyStimulus("done_hold", 1'b0, 1'b1, "a", 3);

    // Stale zero on the first RUN cycle, then a real countdown to zero.
    applyStimulus("expire.arm", 1'b1, 1'b0, 8'h00, 0);
    applyStimulus("expire.stale0", 1'b0, 1'b0, 8'h00, 0);
    applyStimulus("expire.stale1", 1'b0, 1'b0, 8'h00, 0);
    for (int t = 9; t >= 0; t--) begin
      applyStimulus("expire.count", 1'b0, 1'b0, 8'h00, t);
    end
    checkValue("expire.timed_out_const", 32'(timed_out), 32'd1);

    // Completing key on the same cycle the timer hits zero.
    startRound("race_match");
    typeKey("race_match.a", "a", 3);
    typeKey("race_match.b", "b", 2);
    typeKey("race_match.c", "c", 1);
    typeKey("race_match.d", "d", 0);

    // Mismatching key on the expiry cycle.
    startRound("race_miss");
    typeKey("race_miss.a", "a", 2);
    typeKey("race_miss.q", "q", 0);

    // Error counter saturation.
    startRound("sat");
    for (int i = 0; i < 258; i++) begin
      typeKey("sat.miss", "z", 7);
    end
    checkValue("sat.error_const", 32'(error_count), 32'd255);

    // Mid-round asynchronous reset with three correct keys.
    startRound("midreset");
    typeKey("midreset.a", "a", 6);
    typeKey("midreset.b", "b", 6);
    typeKey("midreset.c", "c", 6);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset.async");
    @(posedge clk);
    #1;
    checkOutput("midreset.held");
    reset = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit st;
      bit kv;
      int tl;
      st = ($urandom_range(0, 7) == 0);
      kv = ($urandom_range(0, 2) != 0);
      tl = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
      applyStimulus("random", st, kv, keyPool[$urandom_range(0, 5)], tl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
